// File: rtl/crc_pkg.sv
// Shared CRC definitions: FSM states, the CRC-32 generator polynomial and default width.
package crc_pkg;
  localparam int CRC_WIDTH = 32;
  localparam logic [32:0] CRC32_POLY = 33'h1_04C1_1DB7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;
endpackage

// File: rtl/crc_div_step.sv
// One bit of polynomial long division: shift the next message bit into the
// remainder and subtract (xor) the generator whenever the top term overflows.
module crc_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             b_i,
  input  logic [WIDTH:0]   poly_i,
  output logic [WIDTH-1:0] rem_o
);
  logic [WIDTH:0] t;
  logic [WIDTH:0] tx;
  logic           unused_top;

  assign t          = {rem_i, b_i};
  assign tx         = t ^ (poly_i & {(WIDTH+1){rem_i[WIDTH-1]}});
  // the x^WIDTH term always cancels (or is dropped) and never reaches the remainder
  assign unused_top = tx[WIDTH];
  assign rem_o      = tx[WIDTH-1:0];
endmodule

// File: rtl/crc32_check.sv
// Bit-serial CRC checker: divides {data, crc_rx} by the latched polynomial,
// one bit per cycle, and reports the remainder plus a saturating failure count.
module crc32_check
  import crc_pkg::*;
#(
  parameter int WIDTH = CRC_WIDTH,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] crc_rx,
  input  logic [WIDTH:0]   polynom_i,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] rem_o,
  output logic             crc_ok,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int MSG_W = 2 * WIDTH;
  localparam int CNT_W = $clog2(MSG_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MSG_W - 1);

  crc_state_e       state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [WIDTH:0]   poly_q, poly_d;
  logic [WIDTH-1:0] rem_q, rem_d, rem_step;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             crc_ok_q, crc_ok_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             accept, last_bit;

  assign accept   = in_valid && (state_q == ST_IDLE);
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

  crc_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .b_i    (msg_q[MSG_W-1]),
    .poly_i (poly_q),
    .rem_o  (rem_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)    state_d = ST_SHIFT;
      ST_SHIFT: if (last_bit)  state_d = ST_DONE;
      ST_DONE:  if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  always_comb begin
    msg_d     = msg_q;
    poly_d    = poly_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rem_out_d = rem_out_q;
    crc_ok_d  = crc_ok_q;
    err_d     = err_q;
    if (accept) begin
      msg_d  = {data, crc_rx};
      poly_d = polynom_i;
      rem_d  = '0;
      cnt_d  = '0;
    end else if (state_q == ST_SHIFT) begin
      rem_d = rem_step;
      msg_d = {msg_q[MSG_W-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
      // results are published only once, on the transition into DONE
      if (last_bit) begin
        rem_out_d = rem_step;
        crc_ok_d  = (rem_step == '0);
        if ((rem_step != '0) && (err_q != '1)) err_d = err_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q     <= '0;
      poly_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      rem_out_q <= '0;
      crc_ok_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      msg_q     <= msg_d;
      poly_q    <= poly_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rem_out_q <= rem_out_d;
      crc_ok_q  <= crc_ok_d;
      err_q     <= err_d;
    end
  end

  assign rem_o   = rem_out_q;
  assign crc_ok  = crc_ok_q;
  assign err_cnt = err_q;
endmodule

// File: doc/crc32_check.md
CRC32_CHECK -- requirements
Module: crc32_check

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: CRC width; the message is 2*WIDTH bits ({data, crc}).
REQ-002 The block SHALL have parameter ERR_W, default 16: width of the check-failure counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data, input, WIDTH bits: received payload word.
REQ-006 The block SHALL have port crc_rx, input, WIDTH bits: received CRC word appended to data.
REQ-007 The block SHALL have port polynom_i, input, WIDTH+1 bits: generator polynomial including the x^WIDTH term.
REQ-008 The block SHALL have port in_valid, input, 1 bit: data, crc_rx and polynom_i are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-010 The block SHALL have port rem_o, output, WIDTH bits: remainder of {data, crc_rx} mod polynomial.
REQ-011 The block SHALL have port crc_ok, output, 1 bit: rem_o == 0.
REQ-012 The block SHALL have port out_valid, output, 1 bit: rem_o and crc_ok are valid.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port err_cnt, output, ERR_W bits: saturating count of results with crc_ok=0.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; a word is accepted on a cycle where in_valid and in_ready are both 1.
REQ-017 On accept, the block SHALL latch msg = {data, crc_rx} (2*WIDTH bits) and poly = polynom_i, clear rem and the bit counter, and go to SHIFT.
REQ-018 Input changes after accept SHALL have no effect until the next accept.
REQ-019 On each SHIFT cycle the block SHALL process one message bit, MSB first: b = msg[2*WIDTH-1]; t = {rem, b} (WIDTH+1 bits); rem <= rem[WIDTH-1] ? (t ^ poly)[WIDTH-1:0] : t[WIDTH-1:0]; msg shifts left by one; the counter increments.
REQ-020 SHIFT SHALL last exactly 2*WIDTH cycles (counter 0..2*WIDTH-1); on the last cycle the FSM goes to DONE.
REQ-021 Latency SHALL be fixed: with accept at cycle T, out_valid=1 from cycle T+2*WIDTH+1 (T+65 for WIDTH=32).
REQ-022 In DONE, out_valid SHALL be 1, and rem_o and crc_ok SHALL be stable until out_ready=1.
REQ-023 On DONE with out_ready=1, the FSM SHALL return to IDLE on the next cycle; no back-to-back accept occurs in the same cycle.
REQ-024 out_valid=0 outside DONE; rem_o and crc_ok SHALL hold their last values outside DONE.
REQ-025 err_cnt SHALL increment by 1 on the cycle the FSM enters DONE with rem != 0.
REQ-026 err_cnt SHALL saturate at all-ones and never wrap.
REQ-027 crc_ok SHALL be the registered value of (rem == 0).
REQ-028 A polynomial with MSB = 0 SHALL be processed with no special-casing; the result is undefined but the FSM SHALL still complete.
REQ-029 Consistency with the team's CRC generator: for any data D, crc_rx = generator CRC of D with CRC_IN = 0 SHALL give crc_ok = 1.

Reset
REQ-030 While rst = 0, the block SHALL be asynchronously in state IDLE with msg, poly, rem, counter, rem_o and err_cnt = 0, crc_ok = 0, and out_valid = 0.
REQ-031 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no output pulse; after deassertion the first accept SHALL behave normally.

Structure
REQ-032 A shared package crc_pkg SHALL hold the FSM state enum, CRC32_POLY = 33'h1_04C1_1DB7, and the default WIDTH.
REQ-033 A sub-module crc_div_step (combinational one-bit division step, inputs rem, b, poly; output next rem) SHALL be used by the block and be shareable with the generator.
REQ-034 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-035 Scenario: poly = CRC32_POLY, data = 0x00000000, crc_rx = 0x00000000 -> rem_o = 0, crc_ok = 1, out_valid exactly 65 cycles after accept.
REQ-036 Scenario: data = 0x00000001, crc_rx = 0x04C11DB7 -> rem_o = 0, crc_ok = 1, err_cnt unchanged.
REQ-037 Scenario: data = 0x00000001, crc_rx = 0x00000000 -> rem_o = 0x04C11DB7, crc_ok = 0, err_cnt +1; then data = 0, crc_rx = 0x00000001 -> rem_o = 0x00000001.
REQ-038 Scenario: hold out_ready = 0 for 10 cycles in DONE -> out_valid, rem_o and in_ready = 0 stable throughout; return to IDLE one cycle after out_ready = 1.
REQ-039 Scenario: assert rst at SHIFT counter = 20 -> out_valid never asserts, all outputs 0; the next transaction gives the correct result.
REQ-040 Scenario: with ERR_W = 2, run 5 failing words -> err_cnt reads 1, 2, 3, 3, 3.
